// File: rtl/div_sequencer_pkg.sv
// Shared pipeline definitions for the execute-stage divide sequencer.
// Holds the state encoding, the default datapath width and its iteration
// count, and the fixed LO value produced by a divide by zero.
package div_sequencer_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int DIV_CYCLES = DIV_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_t;

    // LO for a zero divisor: all ones regardless of DIV/DIVU.
    localparam logic [DIV_WIDTH-1:0] DIVZ_LO = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// Ports:
//   i_rem, i_quo : current partial remainder / quotient (dividend bits shift out of quo)
//   i_div        : divisor magnitude
//   o_rem, o_quo : pair after shift-left-by-one and conditional subtract
module div_step
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    // The shifted remainder needs one extra bit: rem < div can be close to
    // 2^WIDTH, so rem<<1 may overflow WIDTH bits.
    logic [WIDTH:0]   w_sh;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    assign w_sh   = {i_rem, i_quo[WIDTH-1]};
    assign w_ge   = (w_sh >= {1'b0, i_div});
    // When w_ge holds the true difference is below 2^WIDTH, so the modular
    // low-bit subtraction is exact.
    assign w_diff = w_sh[WIDTH-1:0] - i_div;

    assign o_rem = w_ge ? w_diff : w_sh[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer for the E stage.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   startE, signedE     : DIV/DIVU in E, signed mode
//   opaE, opbE          : dividend / divisor, captured in IDLE
//   annulE, holdE       : E flush (abort), external E stall
//   stall_divE          : stall request to the hazard unit (combinational)
//   readyE, hiE, loE    : result valid, remainder, quotient (registered)
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] opaE,
    input  logic [WIDTH-1:0] opbE,
    input  logic             annulE,
    input  logic             holdE,
    output logic             stall_divE,
    output logic             readyE,
    output logic [WIDTH-1:0] hiE,
    output logic [WIDTH-1:0] loE
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_t       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem, r_quo, r_div;
    logic             r_neg_q, r_neg_r;
    logic             r_ready;
    logic [WIDTH-1:0] r_hi, r_lo;

    logic             w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic [WIDTH-1:0] w_rem_n, w_quo_n;
    logic [WIDTH-1:0] w_hi_fix, w_lo_fix;

    // Magnitudes on capture; DIVU operands pass through untouched.
    assign w_a_neg = signedE & opaE[WIDTH-1];
    assign w_b_neg = signedE & opbE[WIDTH-1];
    assign w_a_mag = w_a_neg ? -opaE : opaE;
    assign w_b_mag = w_b_neg ? -opbE : opbE;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_n),
        .o_quo (w_quo_n)
    );

    // Sign fixup applied to the final step's output. 0x80000000 / -1 wraps
    // back to 0x80000000 naturally through the two's-complement negate.
    assign w_lo_fix = r_neg_q ? -w_quo_n : w_quo_n;
    assign w_hi_fix = r_neg_r ? -w_rem_n : w_rem_n;

    // Not stalled in DONE, so the instruction leaves E in the ready cycle.
    assign stall_divE = startE & ~annulE & (r_state != DONE);
    assign readyE     = r_ready;
    assign hiE        = r_hi;
    assign loE        = r_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_ready <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (startE && !annulE) begin
                        if (opbE == '0) begin
                            r_state <= DONE;
                            r_ready <= 1'b1;
                            r_lo    <= DIVZ_LO[WIDTH-1:0];
                            r_hi    <= opaE;
                        end else begin
                            r_state <= BUSY;
                            r_cnt   <= '0;
                            r_rem   <= '0;
                            r_quo   <= w_a_mag;
                            r_div   <= w_b_mag;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                        end
                    end
                end
                BUSY: begin
                    if (annulE) begin
                        r_state <= IDLE;
                    end else begin
                        r_rem <= w_rem_n;
                        r_quo <= w_quo_n;
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == LAST) begin
                            r_state <= DONE;
                            r_ready <= 1'b1;
                            r_lo    <= w_lo_fix;
                            r_hi    <= w_hi_fix;
                        end
                    end
                end
                DONE: begin
                    if (annulE || !holdE) begin
                        r_state <= IDLE;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
